// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared constants for the stopwatch core.
//   - FSM state encodings (legacy 2-bit values seen on the state output)
//   - BCD wrap limits and helpers that split the minute limit into digits
//   - button decode type used for clear > start > lap priority
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_LAP   = 2'd3;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_FIVE = 4'd5;

    typedef enum logic [1:0] {
        BTN_NONE  = 2'd0,
        BTN_LAP   = 2'd1,
        BTN_START = 2'd2,
        BTN_CLEAR = 2'd3
    } btn_e;

    function automatic logic [3:0] min_tens(input int unsigned max_min);
        return 4'(max_min / 10);
    endfunction

    function automatic logic [3:0] min_ones(input int unsigned max_min);
        return 4'(max_min % 10);
    endfunction

endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// bcd_digit: one BCD counter digit with programmable wrap limit.
//   clk_50mhz, rst_n : clock, async active-low reset
//   inc              : advance this digit
//   clr              : synchronous clear to 0 (wins over inc)
//   limit[3:0]       : last value before wrapping to 0
//   q[3:0]           : current digit value
//   carry            : inc & (q == limit), feeds the next digit's inc
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       clk_50mhz,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    input  logic [3:0] limit,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = (q_q == limit) ? '0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc & (q_q == limit);

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: start/pause/lap/clear stopwatch with BCD mm:ss.cc count
// and a six-digit multiplexed display scan.
//   clk_50mhz, rst_n      : clock, async active-low reset
//   clk_100hz, clk_1khz   : divider square waves, edge-detected into ticks
//   btn_start/lap/clear   : single-cycle debounced button pulses
//   state[1:0]            : IDLE=0 RUN=1 PAUSE=2 LAP=3
//   an[5:0]               : active-low digit enables, an[0] = cs ones
//   digit[3:0]            : BCD nibble of the enabled digit
//   dp                    : active-low decimal point (scan index 2 and 4)
//   overflow              : one-cycle pulse on wrap from MAX_MIN:59.99
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned SCAN_DIGITS = 6,
    parameter int unsigned MAX_MIN     = 59
) (
    input  logic       clk_50mhz,
    input  logic       rst_n,
    input  logic       clk_100hz,
    input  logic       clk_1khz,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic [1:0] state,
    output logic [5:0] an,
    output logic [3:0] digit,
    output logic       dp,
    output logic       overflow
);

    localparam logic [3:0] MIN_TENS = min_tens(MAX_MIN);
    localparam logic [3:0] MIN_ONES = min_ones(MAX_MIN);
    localparam logic [2:0] LAST_IDX = 3'(SCAN_DIGITS - 1);

    logic        prev_100_q, prev_1k_q;
    logic        tick_cs, tick_scan;
    logic [1:0]  state_q, state_d;
    logic [23:0] lap_q, lap_d;
    logic [23:0] cnt;
    logic [23:0] disp;
    logic [5:0]  inc, carry;
    logic [3:0]  lim [6];
    logic        count_en, clr_cnt;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  disp_nib;
    logic [5:0]  an_q;
    logic [3:0]  digit_q;
    logic        dp_q, ovf_q;
    btn_e        btn;

    assign tick_cs   = clk_100hz & ~prev_100_q;
    assign tick_scan = clk_1khz & ~prev_1k_q;

    always_comb begin
        if (btn_clear)      btn = BTN_CLEAR;
        else if (btn_start) btn = BTN_START;
        else if (btn_lap)   btn = BTN_LAP;
        else                btn = BTN_NONE;
    end

    // Counting is gated by the pre-transition state, so a tick coinciding
    // with start in RUN is still counted and lap captures the old value.
    assign count_en = tick_cs & ((state_q == ST_RUN) | (state_q == ST_LAP));

    always_comb begin
        state_d = state_q;
        lap_d   = lap_q;
        clr_cnt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn == BTN_START) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (btn == BTN_START) begin
                    state_d = ST_PAUSE;
                end else if (btn == BTN_LAP) begin
                    lap_d   = cnt;
                    state_d = ST_LAP;
                end
            end
            ST_LAP: begin
                if (btn == BTN_LAP)        state_d = ST_RUN;
                else if (btn == BTN_START) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (btn == BTN_START) begin
                    state_d = ST_RUN;
                end else if (btn == BTN_CLEAR) begin
                    state_d = ST_IDLE;
                    lap_d   = '0;
                    clr_cnt = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Minute ones wraps at 9 normally, but at MAX_MIN's ones digit once the
    // tens digit has reached MAX_MIN's tens digit.
    always_comb begin
        lim[0] = BCD_NINE;
        lim[1] = BCD_NINE;
        lim[2] = BCD_NINE;
        lim[3] = BCD_FIVE;
        lim[4] = (cnt[23:20] == MIN_TENS) ? MIN_ONES : BCD_NINE;
        lim[5] = MIN_TENS;
    end

    assign inc = {carry[4:0], count_en};

    for (genvar k = 0; k < 6; k++) begin : g_digit
        bcd_digit u_digit (
            .clk_50mhz (clk_50mhz),
            .rst_n     (rst_n),
            .inc       (inc[k]),
            .clr       (clr_cnt),
            .limit     (lim[k]),
            .q         (cnt[4*k +: 4]),
            .carry     (carry[k])
        );
    end

    assign disp  = (state_q == ST_LAP) ? lap_q : cnt;
    assign idx_d = tick_scan ? ((idx_q == LAST_IDX) ? '0 : idx_q + 3'd1) : idx_q;

    always_comb begin
        case (idx_q)
            3'd0:    disp_nib = disp[3:0];
            3'd1:    disp_nib = disp[7:4];
            3'd2:    disp_nib = disp[11:8];
            3'd3:    disp_nib = disp[15:12];
            3'd4:    disp_nib = disp[19:16];
            3'd5:    disp_nib = disp[23:20];
            default: disp_nib = '0;
        endcase
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            prev_100_q <= 1'b0;
            prev_1k_q  <= 1'b0;
            state_q    <= ST_IDLE;
            lap_q      <= '0;
            idx_q      <= '0;
            an_q       <= 6'b111110;
            digit_q    <= '0;
            dp_q       <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            prev_100_q <= clk_100hz;
            prev_1k_q  <= clk_1khz;
            state_q    <= state_d;
            lap_q      <= lap_d;
            idx_q      <= idx_d;
            an_q       <= ~(6'd1 << idx_q);
            digit_q    <= disp_nib;
            dp_q       <= ~((idx_q == 3'd2) | (idx_q == 3'd4));
            ovf_q      <= carry[5];
        end
    end

    assign state    = state_q;
    assign an       = an_q;
    assign digit    = digit_q;
    assign dp       = dp_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

    logic       clk;
    logic       rst_n;
    logic       c100, c1k, bs, bl, bc;
    logic [1:0] state0, state1;
    logic [5:0] an0, an1;
    logic [3:0] digit0, digit1;
    logic       dp0, dp1, ovf0, ovf1;

    int checks = 0;
    int errors = 0;

    // Instance 0: standard 59-minute wrap. Instance 1: MAX_MIN=0 so the
    // minute wrap and overflow pulse are reachable in a short run.
    stopwatch_core #(.SCAN_DIGITS(6), .MAX_MIN(59)) dut0 (
        .clk_50mhz (clk), .rst_n (rst_n), .clk_100hz (c100), .clk_1khz (c1k),
        .btn_start (bs), .btn_lap (bl), .btn_clear (bc),
        .state (state0), .an (an0), .digit (digit0), .dp (dp0), .overflow (ovf0)
    );

    stopwatch_core #(.SCAN_DIGITS(6), .MAX_MIN(0)) dut1 (
        .clk_50mhz (clk), .rst_n (rst_n), .clk_100hz (c100), .clk_1khz (c1k),
        .btn_start (bs), .btn_lap (bl), .btn_clear (bc),
        .state (state1), .an (an1), .digit (digit1), .dp (dp1), .overflow (ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: count and lap held as total centiseconds.
    int wrap [2] = '{60 * 6000, 1 * 6000};
    int m_state [2], m_cnt [2], m_lap [2], m_idx [2], m_shown [2];
    int e_an [2], e_digit [2], e_dp [2], e_ovf [2];
    int m_p100, m_p1k;

    function automatic int digit_of(input int t, input int idx);
        int cs, s, m;
        cs = t % 100;
        s  = (t / 100) % 60;
        m  = t / 6000;
        case (idx)
            0: return cs % 10;
            1: return cs / 10;
            2: return s % 10;
            3: return s / 10;
            4: return m % 10;
            default: return m / 10;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0; m_cnt[i] = 0; m_lap[i] = 0; m_idx[i] = 0; m_shown[i] = 0;
            e_an[i] = 62; e_digit[i] = 0; e_dp[i] = 1; e_ovf[i] = 0;
        end
        m_p100 = 0;
        m_p1k  = 0;
    endtask

    task automatic model_step();
        int tcs, tsc, btn, disp, nxt, ns;
        tcs = (c100 && m_p100 == 0) ? 1 : 0;
        tsc = (c1k && m_p1k == 0) ? 1 : 0;
        btn = bc ? 3 : bs ? 2 : bl ? 1 : 0;
        for (int i = 0; i < 2; i++) begin
            disp       = (m_state[i] == 3) ? m_lap[i] : m_cnt[i];
            e_digit[i] = digit_of(disp, m_idx[i]);
            e_an[i]    = 63 & ~(1 << m_idx[i]);
            e_dp[i]    = (m_idx[i] == 2 || m_idx[i] == 4) ? 0 : 1;
            m_shown[i] = m_idx[i];
            e_ovf[i]   = 0;
            nxt        = m_cnt[i];
            if (tcs == 1 && (m_state[i] == 1 || m_state[i] == 3)) begin
                nxt = m_cnt[i] + 1;
                if (nxt == wrap[i]) begin
                    nxt      = 0;
                    e_ovf[i] = 1;
                end
            end
            ns = m_state[i];
            case (m_state[i])
                0: if (btn == 2) ns = 1;
                1: if (btn == 2) ns = 2;
                   else if (btn == 1) begin m_lap[i] = m_cnt[i]; ns = 3; end
                3: if (btn == 1) ns = 1;
                   else if (btn == 2) ns = 2;
                default: if (btn == 2) ns = 1;
                   else if (btn == 3) begin ns = 0; nxt = 0; m_lap[i] = 0; end
            endcase
            m_state[i] = ns;
            m_cnt[i]   = nxt;
            if (tsc == 1) m_idx[i] = (m_idx[i] + 1) % 6;
        end
        m_p100 = c100 ? 1 : 0;
        m_p1k  = c1k ? 1 : 0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("state0", state0, m_state[0]);  check("state1", state1, m_state[1]);
        check("an0", an0, e_an[0]);           check("an1", an1, e_an[1]);
        check("digit0", digit0, e_digit[0]);  check("digit1", digit1, e_digit[1]);
        check("dp0", dp0, e_dp[0]);           check("dp1", dp1, e_dp[1]);
        check("ovf0", ovf0, e_ovf[0]);        check("ovf1", ovf1, e_ovf[1]);
    endtask

    task automatic cycle(input logic a100, input logic a1k, input logic s,
                         input logic l, input logic c);
        c100 = a100; c1k = a1k; bs = s; bl = l; bc = c;
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            cycle(1, 0, 0, 0, 0);
            cycle(0, 0, 0, 0, 0);
        end
    endtask

    task automatic press(input logic s, input logic l, input logic c);
        cycle(0, 0, s, l, c);
    endtask

    // Walk the scan through all six digits and compare against BCD constants
    // given as {m10,m1,s10,s1,cs10,cs1}.
    task automatic check_display(input logic [23:0] exp0, input logic [23:0] exp1);
        for (int k = 0; k < 6; k++) begin
            cycle(0, 1, 0, 0, 0);
            cycle(0, 0, 0, 0, 0);
            check("disp0", digit0, int'(exp0[4*m_shown[0] +: 4]));
            check("disp1", digit1, int'(exp1[4*m_shown[1] +: 4]));
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_state0", state0, 0);  check("rst_state1", state1, 0);
        check("rst_an0", an0, 62);       check("rst_an1", an1, 62);
        check("rst_digit0", digit0, 0);  check("rst_digit1", digit1, 0);
        check("rst_dp0", dp0, 1);        check("rst_dp1", dp1, 1);
        check("rst_ovf0", ovf0, 0);      check("rst_ovf1", ovf1, 0);
    endtask

    task automatic do_reset();
        c100 = 0; c1k = 0; bs = 0; bl = 0; bc = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_reset_outputs();
    endtask

    typedef struct {
        logic       a100, a1k, s, l, c;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs [15];
    logic [5:0] scan_an [7];
    logic       scan_dp [7];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{0, 0, 0, 0, 1, 2'd0};
        vecs[1]  = '{0, 0, 0, 1, 0, 2'd0};
        vecs[2]  = '{0, 0, 1, 0, 0, 2'd1};
        vecs[3]  = '{0, 0, 0, 0, 1, 2'd1};
        vecs[4]  = '{0, 0, 0, 1, 0, 2'd3};
        vecs[5]  = '{0, 0, 0, 1, 0, 2'd1};
        vecs[6]  = '{0, 0, 1, 1, 0, 2'd2};
        vecs[7]  = '{0, 0, 0, 1, 0, 2'd2};
        vecs[8]  = '{0, 0, 1, 0, 0, 2'd1};
        vecs[9]  = '{0, 0, 1, 0, 0, 2'd2};
        vecs[10] = '{0, 0, 1, 0, 1, 2'd0};
        vecs[11] = '{0, 0, 1, 0, 0, 2'd1};
        vecs[12] = '{0, 0, 0, 1, 0, 2'd3};
        vecs[13] = '{0, 0, 1, 0, 0, 2'd2};
        vecs[14] = '{0, 0, 0, 0, 1, 2'd0};
        scan_an = '{6'b111101, 6'b111011, 6'b110111, 6'b101111,
                    6'b011111, 6'b111110, 6'b111101};
        scan_dp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        do_reset();

        // FSM transition table
        for (int v = 0; v < 15; v++) begin
            cycle(vecs[v].a100, vecs[v].a1k, vecs[v].s, vecs[v].l, vecs[v].c);
            check("fsm_vec0", state0, int'(vecs[v].exp_state));
            check("fsm_vec1", state1, int'(vecs[v].exp_state));
        end

        // Start and count 150 ticks
        press(1, 0, 0);
        tick_n(150);
        check("run_state", state0, 1);
        check_display(24'h000150, 24'h000150);

        // Lap at 00:00.37, then 20 more ticks
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        tick_n(37);
        press(0, 1, 0);
        tick_n(20);
        check("lap_state", state0, 3);
        check_display(24'h000037, 24'h000037);
        press(0, 1, 0);
        check_display(24'h000057, 24'h000057);

        // Pause and clear
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        tick_n(10);
        press(1, 0, 0);
        check("pause_state", state0, 2);
        tick_n(5);
        check_display(24'h000010, 24'h000010);
        press(1, 0, 1);
        check("clear_state", state0, 0);
        check_display(24'h000000, 24'h000000);

        // Tick coinciding with buttons
        press(1, 0, 0);
        tick_n(5);
        cycle(1, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        check_display(24'h000006, 24'h000006);
        press(0, 1, 0);
        check_display(24'h000007, 24'h000007);
        press(1, 0, 0);
        press(0, 0, 1);

        // Carry chain and minute wrap
        press(1, 0, 0);
        tick_n(5999);
        check_display(24'h005999, 24'h005999);
        cycle(1, 0, 0, 0, 0);
        check("wrap_ovf0", ovf0, 0);
        check("wrap_ovf1", ovf1, 1);
        cycle(0, 0, 0, 0, 0);
        check("wrap_ovf1_end", ovf1, 0);
        check_display(24'h010000, 24'h000000);

        // Randomized stimulus against the model
        for (int r = 0; r < 3000; r++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 7) == 0));
        end

        // Scan sequence from reset
        do_reset();
        for (int k = 0; k < 7; k++) begin
            cycle(0, 1, 0, 0, 0);
            cycle(0, 0, 0, 0, 0);
            check("scan_an", an0, int'(scan_an[k]));
            check("scan_dp", dp0, int'(scan_dp[k]));
        end

        // Asynchronous reset mid-count, checked before any clock edge
        press(1, 0, 0);
        tick_n(23);
        cycle(0, 1, 0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_display(24'h000000, 24'h000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Stopwatch timing core for the exam board, downstream of `frequency_divider`. It takes the divider's 100 Hz and 1 kHz square waves and converts each one to a single-cycle enable. It then runs a start/pause/lap/clear state machine with a BCD mm:ss.cc counter, and time-multiplexes six BCD digits for the 7-segment decoder stage.

## Interface
- `SCAN_DIGITS`, 6: number of multiplexed digits. Fixed at 6; other values are unsupported.
- `MAX_MIN`, 59: last minute value before wrap-around.
- `clk_50mhz`, in, 1: system clock.
- `rst_n`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `clk_100hz`, in, 1: 100 Hz square wave from the divider, synchronous to `clk_50mhz`.
- `clk_1khz`, in, 1: 1 kHz square wave from the divider, synchronous to `clk_50mhz`.
- `btn_start`, in, 1: start/stop. Single-cycle pulse, already debounced.
- `btn_lap`, in, 1: lap toggle. Single-cycle pulse.
- `btn_clear`, in, 1: clear. Single-cycle pulse.
- `state`, out, 2: FSM state, encoded IDLE=0, RUN=1, PAUSE=2, LAP=3.
- `an`, out, 6: digit enables, active-low. `an[0]` is the centiseconds-ones digit.
- `digit`, out, 4: BCD value of the currently enabled digit.
- `dp`, out, 1: decimal point, active-low. Driven low while scan index is 2 or 4.
- `overflow`, out, 1: one-cycle pulse when the count wraps from MAX_MIN:59.99.

## Operation
- **Edge enables.**
  - `tick_cs = clk_100hz & ~prev_100`.
  - `tick_scan = clk_1khz & ~prev_1k`.
  - `prev_*` registers reset to 0. A source that is high when reset releases therefore produces one tick.
- **Counter.** Six BCD nibbles: cs1, cs10, s1, s10, m1, m10.
  - Increments on `tick_cs` only when the current (pre-transition) state is RUN or LAP.
  - cs wraps 99→00 and carries into seconds.
  - Seconds wrap 59→00 and carry into minutes.
  - Minutes wrap MAX_MIN→00. At that wrap `overflow` pulses and the count continues from 00:00.00.
- **Button priority:** clear > start > lap. Only the highest-priority asserted button acts in a given cycle.
- **FSM transitions:**
  - IDLE: start→RUN. Clear and lap are no-ops.
  - RUN: start→PAUSE. Lap copies the live count into `lap_reg` and goes to LAP. Clear is ignored.
  - LAP: counting continues and the display shows `lap_reg`. Lap→RUN. Start→PAUSE. Clear is ignored.
  - PAUSE: start→RUN. Clear zeroes the count and `lap_reg` and goes to IDLE. Lap is ignored.
- **Display source:** `lap_reg` in LAP, the live count in every other state.
- **Scan.**
  - Scan index runs 0..5 and advances on `tick_scan`, wrapping 5→0.
  - `an` is all ones except bit[index].
  - `digit` is the display-source nibble for that index, in the order cs1, cs10, s1, s10, m1, m10.

## Timing
- **Reset values:**
  - `state`=IDLE.
  - Count and `lap_reg` = 0.
  - Scan index = 0.
  - `an`=6'b111110, `digit`=0, `dp`=1, `overflow`=0.
- `tick_cs` is combinational. The counter updates at the clock edge that ends the first cycle in which `clk_100hz` is 1. The new count is visible one cycle after the input rises.
- `an`, `digit` and `dp` are registered from the scan index and the display source. They lag the index or count change by one cycle.
- **Simultaneous tick and button:**
  - Tick with start in RUN: the tick is counted, then the FSM enters PAUSE.
  - Tick with start in PAUSE: the tick is not counted.
  - Tick with lap in RUN: `lap_reg` captures the pre-increment value.
- `overflow` is asserted in the same cycle the counter register shows 00:00.00 after the wrap.
- `rst_n` low at any time clears everything asynchronously, including in the middle of a scan or a count. No partial state survives.

## Structure
- Package `stopwatch_pkg`:
  - State encoding constants.
  - BCD limits: 9, 5, and `MAX_MIN` split into tens and ones digits.
- Sub-module `bcd_digit`:
  - Ports: `clk_50mhz`, `rst_n`, `inc`, `clr`, `limit[3:0]`, `q[3:0]`, `carry`.
  - `carry = inc & (q==limit)`.
  - Six instances are chained into the counter.

## Test plan
- **Start and count:** reset, start, then 150 `clk_100hz` rising edges → count 00:01.50, `state`=1.
- **Seconds and minutes carry:** preload by running to 00:59.99, then one more edge → 01:00.00.
- **Minute carry:** from 59:59.99 (MAX_MIN=59), one edge → 00:00.00 and a one-cycle `overflow` pulse.
- **Lap:**
  - Lap at 00:00.37, then 20 ticks → `digit` shows 7,3,0,0,0,0 across the scan while the live count is 00:00.57.
  - Lap again → display shows the live count.
- **Pause and clear:**
  - Start, 10 ticks, start → PAUSE.
  - 5 more ticks → count stays 00:00.10.
  - Clear with start in the same cycle → IDLE, count 0.
- **Scan and async reset:**
  - 7 `clk_1khz` edges → `an` sequence 111101…111110…111101, with `dp` low on index 2 and 4.
  - Drop `rst_n` mid-run → all outputs at their reset values immediately, without waiting for a clock edge.
